// File: rtl/knn_select.sv
// knn_select: keeps the K smallest column distance sums of a frame
// in ascending order, then streams them out nearest-first.
module knn_select #(
  parameter int SUM_LEN = 10,
  parameter int IDX_LEN = 8,
  parameter int K       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SUM_LEN-1:0] inS,
  input  logic [IDX_LEN-1:0] inIdx,
  input  logic               in_vld,
  input  logic               in_last,
  output logic               in_rdy,
  output logic [SUM_LEN-1:0] outS,
  output logic [IDX_LEN-1:0] outIdx,
  output logic               out_vld,
  output logic               out_last,
  input  logic               out_rdy
);

  localparam int CW = $clog2(K + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ptr_q, ptr_d;

  logic [SUM_LEN-1:0] s_q [K];
  logic [SUM_LEN-1:0] s_d [K];
  logic [IDX_LEN-1:0] i_q [K];
  logic [IDX_LEN-1:0] i_d [K];

  logic [SUM_LEN-1:0] sh_s [K];
  logic [IDX_LEN-1:0] sh_i [K];

  logic [K-1:0] lt;
  logic [K-1:0] prv;

  logic acc;
  logic take;
  logic last_q;

  assign acc  = in_vld & in_rdy;
  assign take = out_vld & out_rdy;

  // Sorted list plus empty slots losing makes lt monotonic 0..01..1
  always_comb begin
    lt   = '0;
    prv  = '0;
    sh_s = '{default: '0};
    sh_i = '{default: '0};
    for (int j = 0; j < K; j++) begin
      if (CW'(j) < cnt_q) begin
        lt[j] = inS < s_q[j];
      end else begin
        lt[j] = 1'b1;
      end
    end
    for (int j = 1; j < K; j++) begin
      prv[j]  = lt[j-1];
      sh_s[j] = s_q[j-1];
      sh_i[j] = i_q[j-1];
    end
  end

  always_comb begin
    s_d = s_q;
    i_d = i_q;
    for (int j = 0; j < K; j++) begin
      unique case (1'b1)
        acc && lt[j] && !prv[j]: begin
          s_d[j] = inS;
          i_d[j] = inIdx;
        end
        acc && lt[j] && prv[j]: begin
          s_d[j] = sh_s[j];
          i_d[j] = sh_i[j];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      COLLECT: begin
        if (acc) begin
          if (cnt_q != CW'(K)) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (in_last) begin
            state_d = DRAIN;
            ptr_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (take) begin
          if (last_q) begin
            state_d = COLLECT;
            cnt_d   = '0;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + CW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      s_q     <= '{default: '0};
      i_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      i_q     <= i_d;
    end
  end

  assign last_q  = ptr_q == (cnt_q - CW'(1));
  assign in_rdy  = state_q == COLLECT;
  assign out_vld = state_q == DRAIN;

  always_comb begin
    outS     = '0;
    outIdx   = '0;
    out_last = 1'b0;
    if (out_vld) begin
      out_last = last_q;
      for (int j = 0; j < K; j++) begin
        if (ptr_q == CW'(j)) begin
          outS   = s_q[j];
          outIdx = i_q[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_select.sv
// tb_knn_select: directed vectors for knn_select (K=4),
// expected entries computed by hand.
module tb_knn_select;

  localparam int SL = 10;
  localparam int IL = 8;
  localparam int K  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SL-1:0] inS;
  logic [IL-1:0] inIdx;
  logic          in_vld;
  logic          in_last;
  logic          in_rdy;
  logic [SL-1:0] outS;
  logic [IL-1:0] outIdx;
  logic          out_vld;
  logic          out_last;
  logic          out_rdy;

  int n_run  = 0;
  int n_fail = 0;

  knn_select #(
    .SUM_LEN(SL),
    .IDX_LEN(IL),
    .K      (K)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inS     (inS),
    .inIdx   (inIdx),
    .in_vld  (in_vld),
    .in_last (in_last),
    .in_rdy  (in_rdy),
    .outS    (outS),
    .outIdx  (outIdx),
    .out_vld (out_vld),
    .out_last(out_last),
    .out_rdy (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic send(input int s, input int idx,
                      input bit last);
    in_vld  = 1'b1;
    inS     = SL'(s);
    inIdx   = IL'(idx);
    in_last = last;
    chk("in_rdy_collect", in_rdy, 1);
    chk("out_vld_collect", out_vld, 0);
    @(negedge clk);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic take(input int s, input int idx,
                      input bit last);
    out_rdy = 1'b1;
    chk("out_vld", out_vld, 1);
    chk("outS", outS, s);
    chk("outIdx", outIdx, idx);
    chk("out_last", out_last, last);
    chk("in_rdy_drain", in_rdy, 0);
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_in_rdy"}, in_rdy, 1);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  task automatic frame_a;
    send(9, 0, 0);
    send(3, 1, 0);
    send(7, 2, 0);
    send(3, 3, 0);
    send(12, 4, 0);
    send(1, 5, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    inS     = '0;
    inIdx   = '0;
    in_vld  = 1'b0;
    in_last = 1'b0;
    out_rdy = 1'b0;

    // 1: reset
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk("rst");
    chk("rst_outS", outS, 0);
    chk("rst_outIdx", outIdx, 0);

    // in_last without in_vld must be ignored
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    idle_chk("lone_last");

    // 2: basic frame with tie and discard
    out_rdy = 1'b1;
    frame_a();
    take(1, 5, 0);
    take(3, 1, 0);
    take(3, 3, 0);
    take(7, 2, 1);
    out_rdy = 1'b0;
    idle_chk("f2_end");

    // 3: short frame
    send(5, 0, 0);
    send(2, 1, 1);
    take(2, 1, 0);
    take(5, 0, 1);
    out_rdy = 1'b0;
    idle_chk("f3_end");

    // 4: backpressure on second entry
    frame_a();
    take(1, 5, 0);
    out_rdy = 1'b0;
    repeat (3) begin
      chk("stall_vld", out_vld, 1);
      chk("stall_outS", outS, 3);
      chk("stall_outIdx", outIdx, 1);
      chk("stall_last", out_last, 0);
      chk("stall_in_rdy", in_rdy, 0);
      @(negedge clk);
    end
    take(3, 1, 0);
    take(3, 3, 0);
    take(7, 2, 1);
    out_rdy = 1'b0;
    idle_chk("f4_end");

    // 5: all equal maximum distances
    for (int i = 10; i < 16; i++) begin
      send(1023, i, i == 15);
    end
    take(1023, 10, 0);
    take(1023, 11, 0);
    take(1023, 12, 0);
    take(1023, 13, 1);
    out_rdy = 1'b0;
    idle_chk("f5_end");

    // 6: reset mid-drain
    frame_a();
    take(1, 5, 0);
    out_rdy = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk("mid_rst");
    chk("mid_rst_outS", outS, 0);
    send(8, 7, 1);
    take(8, 7, 1);
    out_rdy = 1'b0;
    idle_chk("f6_end");

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
